// File: rtl/bcd_pkg.sv
// Shared types and BCD constants for the digit-serial BCD subtractor.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, CMP, SUB, DONE} state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_BASE = 4'd10;

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtract: d = x - y - bin, wrapped into 0..9 with borrow out.
// Purely combinational (zero latency), no flow control.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [4:0] w_raw;

  always_comb begin
    w_raw = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
    bout  = w_raw[4];
    // A negative raw result wraps mod 16, so adding ten lands back in 0..9.
    d     = w_raw[3:0] + (w_raw[4] ? BCD_BASE : 4'd0);
  end

endmodule

// File: rtl/bcd_sub_seq.sv
// Digit-serial |a-b| in packed BCD: MSD-first magnitude compare, then LSD-first borrow-chain subtract.
// Latency k+NDIG+1 cycles (1 on bad input); result holds in DONE until out_ready, operands accepted only in IDLE.
module bcd_sub_seq
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] diff,
  output logic              neg,
  output logic              err,
  output logic              busy
);

  localparam int            W    = 4 * NDIG;
  localparam int            IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_diff;
  logic [IW-1:0] r_idx;
  logic          r_borrow;
  logic          r_neg;
  logic          r_err;
  logic          r_out_valid;

  logic          w_accept;
  logic          w_handshake;
  logic          w_in_err;
  logic [3:0]    w_a_dig;
  logic [3:0]    w_b_dig;
  logic [3:0]    w_x;
  logic [3:0]    w_y;
  logic [3:0]    w_d;
  logic          w_bout;

  assign in_ready    = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign out_valid   = r_out_valid;
  assign diff        = r_diff;
  assign neg         = r_neg;
  assign err         = r_err;
  assign w_accept    = in_valid && in_ready;
  assign w_handshake = r_out_valid && out_ready;

  always_comb begin
    w_in_err = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (!is_bcd(a[4*i +: 4]) || !is_bcd(b[4*i +: 4])) w_in_err = 1'b1;
    end
  end

  // Digit select for the shared compare/subtract datapath.
  always_comb begin
    w_a_dig = 4'd0;
    w_b_dig = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (IW'(i) == r_idx) begin
        w_a_dig = r_a[4*i +: 4];
        w_b_dig = r_b[4*i +: 4];
      end
    end
  end

  assign w_x = r_neg ? w_b_dig : w_a_dig;
  assign w_y = r_neg ? w_a_dig : w_b_dig;

  bcd_digit_sub u_digit_sub (
    .x    (w_x),
    .y    (w_y),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_in_err ? DONE : CMP;
      CMP:  if ((w_a_dig != w_b_dig) || (r_idx == '0)) w_next = SUB;
      SUB:  if (r_idx == LAST) w_next = DONE;
      DONE: if (w_handshake) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_idx       <= '0;
      r_borrow    <= 1'b0;
      r_neg       <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // Registered from the state, so valid appears one cycle after entering DONE.
      r_out_valid <= (r_state == DONE) && !w_handshake;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_diff   <= '0;
            r_neg    <= 1'b0;
            r_err    <= w_in_err;
            r_idx    <= LAST;
            r_borrow <= 1'b0;
          end
        end
        CMP: begin
          if (w_a_dig != w_b_dig) begin
            r_neg <= (w_a_dig < w_b_dig);
            r_idx <= '0;
          end else if (r_idx == '0) begin
            r_neg <= 1'b0;
            r_idx <= '0;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        SUB: begin
          for (int i = 0; i < NDIG; i++) begin
            if (IW'(i) == r_idx) r_diff[4*i +: 4] <= w_d;
          end
          r_borrow <= w_bout;
          r_idx    <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Larger minus smaller magnitude can never borrow out of the top digit.
  a_no_final_borrow: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == SUB && r_idx == LAST) |-> !w_bout);

  a_valid_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(out_valid && in_ready));

endmodule
